// File: rtl/freq_disp_pkg.sv
// Shared types and constants for the frequency BCD readout and 7-segment scan.
package freq_disp_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned FREQ_W     = 12;
    localparam int unsigned BCD_W      = 4 * NUM_DIGITS;
    localparam int unsigned BCD_OUT_W  = BCD_W - 1;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned BIT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Active-low segment patterns {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/freq_bcd_display_ctrl_if.sv
// Conversion request / result bus between the front-panel logic and the readout controller.
interface freq_bcd_display_ctrl_if;
    import freq_disp_pkg::*;

    logic [FREQ_W-1:0]    freq_in;
    logic                 freq_valid;
    logic                 busy;
    logic [BCD_OUT_W-1:0] bcd_out;
    logic                 bcd_valid;

    modport master (output freq_in, freq_valid, input busy, bcd_out, bcd_valid);
    modport slave  (input freq_in, freq_valid, output busy, bcd_out, bcd_valid);

endinterface

// File: rtl/bcd_seg_decode.sv
// Combinational BCD digit to active-low 7-segment pattern, with forced blank.
module bcd_seg_decode
    import freq_disp_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [7:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_c = SEG_0;
                4'd1:    seg_c = SEG_1;
                4'd2:    seg_c = SEG_2;
                4'd3:    seg_c = SEG_3;
                4'd4:    seg_c = SEG_4;
                4'd5:    seg_c = SEG_5;
                4'd6:    seg_c = SEG_6;
                4'd7:    seg_c = SEG_7;
                4'd8:    seg_c = SEG_8;
                4'd9:    seg_c = SEG_9;
                default: seg_c = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/freq_bcd_display_ctrl.sv
// Frequency readout: sequential shift-and-add-3 binary-to-BCD conversion and
// multiplexed 4-digit 7-segment scan of the last committed result.
module freq_bcd_display_ctrl
    import freq_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    freq_bcd_display_ctrl_if.slave bus,
    output logic [3:0]             an,
    output logic [7:0]             seg
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);

    state_e               state_q, state_d;
    logic [FREQ_W-1:0]    sr_q, sr_d;
    logic [BCD_W-1:0]     work_q, work_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic [BCD_OUT_W-1:0] bcd_q, bcd_d;
    logic [BCD_W-1:0]     disp_q, disp_d;
    logic                 armed_q, armed_d;
    logic [SCAN_W-1:0]    scan_q, scan_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [3:0]           an_q, an_d;
    logic [7:0]           seg_q, seg_d;
    logic [BCD_W-1:0]     adj_c;
    logic                 lz_c;
    logic [3:0]           digit_c;

    // Add-3 correction on every nibble that would overflow past 9 after doubling
    always_comb begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            adj_c[4*i +: 4] = (work_q[4*i +: 4] >= 4'd5) ? work_q[4*i +: 4] + 4'd3
                                                         : work_q[4*i +: 4];
        end
    end

    // Conversion FSM; armed_q drops a request coinciding with reset release
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        work_d  = work_q;
        bit_d   = bit_q;
        bcd_d   = bcd_q;
        disp_d  = disp_q;
        valid_d = 1'b0;
        armed_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (armed_q && bus.freq_valid) begin
                    sr_d    = bus.freq_in;
                    work_d  = '0;
                    bit_d   = BIT_W'(FREQ_W - 1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                work_d = BCD_W'({adj_c, sr_q[FREQ_W-1]});
                sr_d   = {sr_q[FREQ_W-2:0], 1'b0};
                bit_d  = bit_q - BIT_W'(1);
                if (bit_q == '0) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                    bcd_d   = work_d[BCD_OUT_W-1:0];
                    disp_d  = work_d;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Digit scan: advance the digit index each time the dwell counter wraps
    always_comb begin
        scan_d = scan_q + SCAN_W'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = idx_q + IDX_W'(1);
        end
        case (idx_d)
            2'd3:    lz_c = (disp_q[15:12] == 4'd0);
            2'd2:    lz_c = (disp_q[15:8] == 8'd0);
            2'd1:    lz_c = (disp_q[15:4] == 12'd0);
            default: lz_c = 1'b0;
        endcase
        digit_c = disp_q[{idx_d, 2'b00} +: 4];
        an_d    = ~(4'b0001 << idx_d);
    end

    bcd_seg_decode u_dec (
        .digit_i (digit_c),
        .blank_i (BLANK_LZ & lz_c),
        .seg_c   (seg_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            work_q  <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            bcd_q   <= '0;
            disp_q  <= '0;
            armed_q <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
            an_q    <= 4'b1110;
            seg_q   <= SEG_0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            work_q  <= work_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            bcd_q   <= bcd_d;
            disp_q  <= disp_d;
            armed_q <= armed_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.bcd_valid = valid_q;
    assign bus.bcd_out   = bcd_q;
    assign an            = an_q;
    assign seg           = seg_q;

endmodule
